// File: rtl/rom_reader_pkg.sv
// Shared types and helpers for the ROM burst reader.
// Optional checksum output is enabled by defining ROM_READER_CHECKSUM_EN.
package rom_reader_pkg;

  localparam int AW_DEFAULT = 10;
  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Head word is visible on rdata whenever valid is high.
module rom_reader_fifo
  import rom_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  localparam int CW = cnt_width(DEPTH),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Avalon-MM burst reader: pipelined single-word ROM reads delivered on a valid/ready stream.
// Define ROM_READER_CHECKSUM_EN to add the csum output (sum of words popped this transfer).
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT
) (
  input  logic          clk_reader_clk,
  input  logic          rst_reader_reset,
  input  logic          cmd_start,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW:0]   cmd_len,
  output logic          cmd_busy,
  output logic          cmd_done,
  output logic [AW-1:0] rom_master_address,
  output logic          rom_master_chipselect,
  output logic          rom_master_clken,
  output logic          rom_master_write,
  output logic [DW-1:0] rom_master_writedata,
  output logic [3:0]    rom_master_byteenable,
  output logic          rom_master_debugaccess,
  input  logic [DW-1:0] rom_master_readdata,
`ifdef ROM_READER_CHECKSUM_EN
  output logic [DW-1:0] csum,
`endif
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  reader_state_t state;
  reader_state_t state_nxt;

  logic [AW-1:0]     addr;
  logic [AW:0]       remaining;
  logic [AW:0]       len_clamped;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic [CW:0]       credit_used;
  logic [DW:0]       head_word;
  logic              start_ok;
  logic              issue;
  logic              pop;

  assign rom_master_clken       = 1'b1;
  assign rom_master_write       = 1'b0;
  assign rom_master_writedata   = '0;
  assign rom_master_byteenable  = 4'hF;
  assign rom_master_debugaccess = 1'b0;

  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
  assign start_ok    = (state == IDLE) && cmd_start;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_vld[i]);
    end
  end

  // Words buffered plus words still in the ROM pipe must never exceed the FIFO capacity.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue = (state == RUN) && (remaining != '0) &&
                 (credit_used < (CW + 1)'(FIFO_DEPTH));

  assign rom_master_chipselect = issue;
  assign rom_master_address    = addr;

  assign out_data = head_word[DW-1:0];
  assign out_last = out_valid && head_word[DW];
  assign pop      = out_valid && out_ready;

  rom_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (clk_reader_clk),
    .reset (rst_reader_reset),
    .push  (pipe_vld[RD_LAT-1]),
    .wdata ({pipe_last[RD_LAT-1], rom_master_readdata}),
    .pop   (pop),
    .rdata (head_word),
    .valid (out_valid),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    cmd_busy  = 1'b0;
    cmd_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start) begin
          state_nxt = (len_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        cmd_busy = 1'b1;
        if (issue && (remaining == (AW + 1)'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        cmd_busy = 1'b1;
        if (pop && out_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        cmd_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_reader_clk) begin
    if (rst_reader_reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        addr      <= cmd_base;
        remaining <= len_clamped;
      end else if (issue) begin
        addr      <= addr + AW'(1);
        remaining <= remaining - (AW + 1)'(1);
      end
      // Each stage marks a read whose data returns RD_LAT cycles after issue.
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (remaining == (AW + 1)'(1));
    end
  end

`ifdef ROM_READER_CHECKSUM_EN
  always_ff @(posedge clk_reader_clk) begin
    if (rst_reader_reset) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (pop) begin
      csum <= csum + out_data;
    end
  end
`endif

endmodule
